// File: rtl/vga_timing_pkg.sv
// Shared VGA mode tables and helpers for the raster timing generator.
// Each mode bundles the sync/porch/display widths with the sync polarities.
package vga_timing_pkg;

  localparam bit POL_POS = 1'b1;
  localparam bit POL_NEG = 1'b0;

  typedef struct packed {
    int h_sync;
    int h_back;
    int h_disp;
    int h_front;
    int v_sync;
    int v_back;
    int v_disp;
    int v_front;
    bit hs_pol;
    bit vs_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480 = '{
    h_sync: 96, h_back: 48, h_disp: 640, h_front: 16,
    v_sync: 2, v_back: 33, v_disp: 480, v_front: 10,
    hs_pol: POL_NEG, vs_pol: POL_NEG};

  localparam vga_mode_t MODE_800X600 = '{
    h_sync: 128, h_back: 88, h_disp: 800, h_front: 40,
    v_sync: 4, v_back: 23, v_disp: 600, v_front: 1,
    hs_pol: POL_POS, vs_pol: POL_POS};

  localparam vga_mode_t MODE_1024X768 = '{
    h_sync: 136, h_back: 160, h_disp: 1024, h_front: 24,
    v_sync: 6, v_back: 29, v_disp: 768, v_front: 3,
    hs_pol: POL_NEG, vs_pol: POL_NEG};

  localparam vga_mode_t MODE_1280X1024 = '{
    h_sync: 112, h_back: 248, h_disp: 1280, h_front: 48,
    v_sync: 3, v_back: 38, v_disp: 1024, v_front: 1,
    hs_pol: POL_POS, vs_pol: POL_POS};

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register that realigns sync/enable with pixel-fetch latency.
// DEPTH=0 degenerates to a wire.
module vga_delay_line #(
  parameter int              WIDTH   = 1,
  parameter int              DEPTH   = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk_i, reset_i, en_i};
    assign q_o = d_i;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        pipe_q <= {DEPTH{RST_VAL}};
      end else if (en_i) begin
        pipe_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign q_o = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: h/v counters, registered coordinates and
// strobes, plus a delay line on hs/vs/de to match downstream fetch latency.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC     = MODE_1280X1024.h_sync,
  parameter int H_BACK     = MODE_1280X1024.h_back,
  parameter int H_DISP     = MODE_1280X1024.h_disp,
  parameter int H_FRONT    = MODE_1280X1024.h_front,
  parameter int V_SYNC     = MODE_1280X1024.v_sync,
  parameter int V_BACK     = MODE_1280X1024.v_back,
  parameter int V_DISP     = MODE_1280X1024.v_disp,
  parameter int V_FRONT    = MODE_1280X1024.v_front,
  parameter bit HS_POL     = MODE_1280X1024.hs_pol,
  parameter bit VS_POL     = MODE_1280X1024.vs_pol,
  parameter int PIPE_DEPTH = 0,
  parameter int FRAME_W    = 8,
  localparam int XW        = clog2_min1(H_DISP),
  localparam int YW        = clog2_min1(V_DISP)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  output logic [XW-1:0]      x_pos_o,
  output logic [YW-1:0]      y_pos_o,
  output logic               de_early_o,
  output logic               sof_o,
  output logic               eol_o,
  output logic [FRAME_W-1:0] frame_cnt_o,
  output logic               vga_hs_o,
  output logic               vga_vs_o,
  output logic               vga_de_o
);

  localparam int H_LIMIT = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_LIMIT = V_SYNC + V_BACK + V_DISP + V_FRONT;
  // +1 so the exclusive active-end bound still fits when the front porch is 0
  localparam int HCW = clog2_min1(H_LIMIT + 1);
  localparam int VCW = clog2_min1(V_LIMIT + 1);

  localparam logic [HCW-1:0] H_LAST   = HCW'(H_LIMIT - 1);
  localparam logic [HCW-1:0] H_SYNC_E = HCW'(H_SYNC);
  localparam logic [HCW-1:0] H_ACT_B  = HCW'(H_SYNC + H_BACK);
  localparam logic [HCW-1:0] H_ACT_E  = HCW'(H_SYNC + H_BACK + H_DISP);
  localparam logic [VCW-1:0] V_LAST   = VCW'(V_LIMIT - 1);
  localparam logic [VCW-1:0] V_SYNC_E = VCW'(V_SYNC);
  localparam logic [VCW-1:0] V_ACT_B  = VCW'(V_SYNC + V_BACK);
  localparam logic [VCW-1:0] V_ACT_E  = VCW'(V_SYNC + V_BACK + V_DISP);

  logic [HCW-1:0]     h_q, h_d;
  logic [VCW-1:0]     v_q, v_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               h_wrap, v_wrap, h_act, v_act;

  logic               hs1_q, hs1_d, vs1_q, vs1_d, de_q, de_d;
  logic               sof_q, sof_d, eol_q, eol_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [2:0]         dl_q;

  always_comb begin
    h_wrap  = (h_q == H_LAST);
    v_wrap  = (v_q == V_LAST);
    h_d     = h_wrap ? '0 : h_q + 1'b1;
    v_d     = v_q;
    frame_d = frame_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + 1'b1;
      if (v_wrap) frame_d = frame_q + 1'b1;
    end

    h_act = (h_q >= H_ACT_B) && (h_q < H_ACT_E);
    v_act = (v_q >= V_ACT_B) && (v_q < V_ACT_E);
    de_d  = h_act && v_act;
    hs1_d = (h_q < H_SYNC_E) ? HS_POL : ~HS_POL;
    vs1_d = (v_q < V_SYNC_E) ? VS_POL : ~VS_POL;
    // subtraction only escapes inside the active window, so wrap is never seen
    x_d   = de_d ? XW'(h_q - H_ACT_B) : '0;
    y_d   = de_d ? YW'(v_q - V_ACT_B) : '0;
    sof_d = (h_q == '0) && (v_q == '0);
    eol_d = h_wrap;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
      hs1_q   <= ~HS_POL;
      vs1_q   <= ~VS_POL;
      de_q    <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (en_i) begin
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      de_q    <= de_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  vga_delay_line #(
    .WIDTH  (3),
    .DEPTH  (PIPE_DEPTH),
    .RST_VAL({~HS_POL, ~VS_POL, 1'b0})
  ) u_dly (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (en_i),
    .d_i    ({hs1_q, vs1_q, de_q}),
    .q_o    (dl_q)
  );

  assign x_pos_o     = x_q;
  assign y_pos_o     = y_q;
  assign de_early_o  = de_q;
  assign sof_o       = sof_q;
  assign eol_o       = eol_q;
  assign frame_cnt_o = frame_q;
  assign vga_hs_o    = dl_q[2];
  assign vga_vs_o    = dl_q[1];
  assign vga_de_o    = dl_q[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Random-enable bench for vga_timing_gen in a tiny 10x6 mode; outputs are
// predicted from the count of en edges since reset using the raster rules.
module tb_vga_timing_gen;

  localparam int HS = 2, HB = 3, HD = 4, HF = 1;
  localparam int VS = 1, VB = 1, VD = 3, VF = 1;
  localparam int HL = HS + HB + HD + HF;
  localparam int VL = VS + VB + VD + VF;
  localparam int FL = HL * VL;
  localparam int DLY = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  logic [1:0] x0, y0, x1, y1;
  logic       de0, sof0, eol0, hs0, vs0, vde0;
  logic       de1, sof1, eol1, hs1, vs1, vde1;
  logic [7:0] fr0;
  logic [1:0] fr1;

  int n;
  int n_chk = 0;
  int n_err = 0;
  int de_cnt;
  int guard;

  vga_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DEPTH(0), .FRAME_W(8)
  ) dut0 (
    .clk_i(clk), .reset_i(rst_n), .en_i(en),
    .x_pos_o(x0), .y_pos_o(y0), .de_early_o(de0), .sof_o(sof0), .eol_o(eol0),
    .frame_cnt_o(fr0), .vga_hs_o(hs0), .vga_vs_o(vs0), .vga_de_o(vde0)
  );

  vga_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DEPTH(DLY), .FRAME_W(2)
  ) dut1 (
    .clk_i(clk), .reset_i(rst_n), .en_i(en),
    .x_pos_o(x1), .y_pos_o(y1), .de_early_o(de1), .sof_o(sof1), .eol_o(eol1),
    .frame_cnt_o(fr1), .vga_hs_o(hs1), .vga_vs_o(vs1), .vga_de_o(vde1)
  );

  always #5 clk = ~clk;

  // Stage-1 value after k en edges reflects counter state index (k-1) mod FL.
  function automatic int hpos(input int k);
    return ((k - 1) % FL) % HL;
  endfunction
  function automatic int vpos(input int k);
    return ((k - 1) % FL) / HL;
  endfunction
  function automatic int m_de(input int k);
    if (k < 1) return 0;
    return (hpos(k) >= HS + HB && hpos(k) < HS + HB + HD &&
            vpos(k) >= VS + VB && vpos(k) < VS + VB + VD) ? 1 : 0;
  endfunction
  function automatic int m_hs(input int k, input int pol);
    if (k < 1) return 1 - pol;
    return (hpos(k) < HS) ? pol : 1 - pol;
  endfunction
  function automatic int m_vs(input int k, input int pol);
    if (k < 1) return 1 - pol;
    return (vpos(k) < VS) ? pol : 1 - pol;
  endfunction
  function automatic int m_x(input int k);
    return (m_de(k) == 1) ? hpos(k) - HS - HB : 0;
  endfunction
  function automatic int m_y(input int k);
    return (m_de(k) == 1) ? vpos(k) - VS - VB : 0;
  endfunction
  function automatic int m_sof(input int k);
    return (k >= 1 && (k - 1) % FL == 0) ? 1 : 0;
  endfunction
  function automatic int m_eol(input int k);
    return (k >= 1 && hpos(k) == HL - 1) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (en edges=%0d, t=%0t)", tag, obs, exp_v, n, $time);
    end
  endtask

  task automatic check_all();
    chk("x_pos",     32'(x0),   32'(m_x(n)));
    chk("y_pos",     32'(y0),   32'(m_y(n)));
    chk("de_early",  32'(de0),  32'(m_de(n)));
    chk("sof",       32'(sof0), 32'(m_sof(n)));
    chk("eol",       32'(eol0), 32'(m_eol(n)));
    chk("frame_cnt", 32'(fr0),  32'((n / FL) % 256));
    chk("vga_hs",    32'(hs0),  32'(m_hs(n, 1)));
    chk("vga_vs",    32'(vs0),  32'(m_vs(n, 1)));
    chk("vga_de",    32'(vde0), 32'(m_de(n)));
    chk("d_x_pos",   32'(x1),   32'(m_x(n)));
    chk("d_sof",     32'(sof1), 32'(m_sof(n)));
    chk("d_eol",     32'(eol1), 32'(m_eol(n)));
    chk("d_de_early",32'(de1),  32'(m_de(n)));
    chk("d_y_pos",   32'(y1),   32'(m_y(n)));
    chk("d_frame2",  32'(fr1),  32'((n / FL) % 4));
    chk("d_vga_hs",  32'(hs1),  32'(m_hs(n - DLY, 0)));
    chk("d_vga_vs",  32'(vs1),  32'(m_vs(n - DLY, 0)));
    chk("d_vga_de",  32'(vde1), 32'(m_de(n - DLY)));
  endtask

  // Called at a negedge; drive en, take one clock, sample at the next negedge.
  task automatic step(input bit e);
    en = e;
    @(posedge clk);
    if (e && rst_n) n++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    n = 0;
    en = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    de_cnt = 0;
    for (int i = 0; i < FL; i++) begin
      step(1'b1);
      if (de0) de_cnt++;
      if (n == 1)  chk("first_sof", 32'(sof0), 32'd1);
      if (n == 3)  chk("hs_drop",   32'(hs0),  32'd0);
      if (n == 11) chk("vs_drop",   32'(vs0),  32'd0);
      if (n == 26) chk("first_de",  32'(de0),  32'd1);
    end
    chk("de_per_frame", 32'(de_cnt), 32'd12);

    while (n < 4 * FL + 5) step(1'b1);
    chk("frame2_wrap", 32'(fr1), 32'd0);

    repeat (40) begin
      step(1'b1); step(1'b0); step(1'b0); step(1'b1);
    end
    repeat (400) step($urandom_range(0, 3) != 0);

    guard = 0;
    while ((n % FL) != 7 + 3 * HL && guard < 2 * FL) begin
      step(1'b1);
      guard++;
    end
    chk("reach_h7v3", 32'(n % FL), 32'(7 + 3 * HL));
    #2 rst_n = 1'b0;
    #1 n = 0;
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    for (int i = 0; i < 70; i++) begin
      step(1'b1);
      if (n == 1)  chk("re_sof",     32'(sof0), 32'd1);
      if (n == 3)  chk("re_hs_drop", 32'(hs0),  32'd0);
      if (n == 11) chk("re_vs_drop", 32'(vs0),  32'd0);
    end
    repeat (300) step($urandom_range(0, 1) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/SVGA raster timing generator; successor to the single-mode sync counter.
- Adds sync polarity selection, a pixel-clock enable, a configurable output delay line (aligns hs/vs/de with downstream pixel-fetch latency), registered coordinates, start-of-frame/end-of-line strobes and a frame counter.
- Sits between the pixel clock domain and the framebuffer reader / RGB output stage.

Parameters:
- H_SYNC, 112, horizontal sync width in pixels
- H_BACK, 248, horizontal back porch
- H_DISP, 1280, horizontal active pixels
- H_FRONT, 48, horizontal front porch
- V_SYNC, 3, vertical sync width in lines
- V_BACK, 38, vertical back porch
- V_DISP, 1024, vertical active lines
- V_FRONT, 1, vertical front porch
- HS_POL, 1, asserted level of vga_hs
- VS_POL, 1, asserted level of vga_vs
- PIPE_DEPTH, 0, extra en-cycles of delay on vga_hs/vga_vs/vga_de; legal range 0..15
- FRAME_W, 8, frame counter width

Derived (localparam):
- H_LIMIT = sum of the H_* values; V_LIMIT likewise.
- XW = max(1, clog2(H_DISP)); YW = max(1, clog2(V_DISP)).

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  pixel enable; all state advances only when en=1
- x_pos  out  XW  active-region column; 0 outside the active region
- y_pos  out  YW  active-region row; 0 outside the active region
- de_early  out  1  active-region flag, aligned with x_pos/y_pos
- sof  out  1  one-en-cycle strobe: counter state (0,0)
- eol  out  1  one-en-cycle strobe: h_cnt = H_LIMIT-1
- frame_cnt  out  FRAME_W  completed-frame count, wraps
- vga_hs  out  1  horizontal sync, delayed
- vga_vs  out  1  vertical sync, delayed
- vga_de  out  1  data enable, delayed

Behaviour:
- Reset (async, reset=0):
  - h_cnt, v_cnt, frame_cnt, x_pos, y_pos = 0.
  - de_early, sof, eol, vga_de = 0.
  - vga_hs = ~HS_POL; vga_vs = ~VS_POL (inactive).
  - Every delay-line stage resets to the same inactive values.
- Counters, on each en=1 edge:
  - h_cnt wraps at H_LIMIT-1 to 0.
  - v_cnt increments on h_cnt wrap and wraps at V_LIMIT-1.
  - frame_cnt increments when both wrap on the same edge; rolls over from 2^FRAME_W-1 to 0.
- Line layout: sync | back | disp | front, sync first. Vertical layout is identical.
- Stage 1 registers, updated on en, computed from current h_cnt/v_cnt:
  - hs1 = HS_POL when h_cnt < H_SYNC, else ~HS_POL; vs1 likewise against V_SYNC.
  - de_early = 1 when H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_DISP and the same holds vertically.
  - x_pos = h_cnt-H_SYNC-H_BACK and y_pos = v_cnt-V_SYNC-V_BACK when de_early is set, else 0.
  - sof and eol as defined in Ports.
- Latency:
  - de_early, x_pos, y_pos, sof, eol: 1 en-cycle after the counter state.
  - vga_hs, vga_vs, vga_de: 1+PIPE_DEPTH en-cycles after the counter state.
  - PIPE_DEPTH=0 drives the stage-1 values directly.
- en=0: counters, stage-1 registers and the delay line all hold. sof and eol hold their value, so consumers must qualify them with en.
- Reset asserted mid-frame: immediate return to reset values. The first en edge after release registers state (0,0): sof=1, hs/vs asserted at stage 1.
- All arithmetic uses counter-width unsigned values. Subtraction results are only used inside the active region, so no underflow is visible.
- No combinational path from inputs to outputs.

Decomposition:
- Package vga_timing_pkg holds mode constant sets (640x480@60, 800x600@60, 1024x768@60, 1280x1024@60) for porch, sync and display values, plus polarity constants.
- Sub-module vga_delay_line(WIDTH, DEPTH, RST_VAL):
  - Enable-gated shift register with async active-low reset.
  - Instantiated once, 3 bits wide, for {hs, vs, de}; DEPTH=0 is a pass-through.

Test Plan (small mode unless stated: H 2/3/4/1 gives H_LIMIT=10; V 1/1/3/1 gives V_LIMIT=6; en=1, PIPE_DEPTH=0):
- Reset held then released:
  - During reset: hs=0, vs=0, de=0, frame_cnt=0.
  - 1st edge: sof=1, hs=1, vs=1.
  - 3rd edge: hs=0.
  - 11th edge: vs=0.
- Active window:
  - de_early first high after edge 26 (h=5, v=2), with x_pos=0 and y_pos=0.
  - x_pos steps 1,2,3, then de_early=0 with x_pos=0.
  - Exactly 12 de_early cycles per 60-cycle frame; last one at x=3, y=2.
- Wrap:
  - eol high after edges 10, 20, ….
  - frame_cnt=1 after edge 60; sof high again after edge 61.
  - With FRAME_W=2, frame_cnt reads 0 after 240 edges.
- Stall: en toggled 1,0,0,1 repeatedly.
  - All outputs hold during en=0.
  - Output sequence indexed by en-cycles matches the en=1 golden model exactly.
- PIPE_DEPTH=3, HS_POL=0, VS_POL=0:
  - vga_de rises 3 en-cycles after de_early.
  - vga_hs low for 2 en-cycles per line; reset level of vga_hs = 1.
  - vga_vs low for 10 en-cycles per frame.
- Reset pulse mid-line at h=7, v=3:
  - All outputs immediately take reset values, including the delay line.
  - Post-release sequence is identical to the first reset test.
